// File: rtl/mac_acc_pkg.sv
// Shared widths, saturation limits and the input-register type for the
// multiply-accumulate back end.
package mac_acc_pkg;

    localparam int ACC_W_DEF = 72;
    localparam int CNT_W_DEF = 16;
    localparam int OUT_W     = 64;

    localparam logic [OUT_W-1:0] SAT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [OUT_W-1:0] SAT_MIN = 64'h8000_0000_0000_0000;

    typedef struct packed {
        logic [OUT_W-1:0] prod;
        logic             last;
        logic             valid;
    } s1_t;

endpackage

// File: rtl/mac_acc_if.sv
// Product-in / result-out bus of mac_accumulator.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; valid never waits on ready, and ready never depends on valid.
interface mac_acc_if #(
    parameter int CNT_W = 16
);
    logic [63:0]      prod;
    logic             prod_valid;
    logic             prod_last;
    logic             prod_ready;
    logic             acc_clr;
    logic [63:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output prod, prod_valid, prod_last, acc_clr, out_ready,
        input  prod_ready, out_data, out_count, out_ovf, out_valid
    );

    modport slave (
        input  prod, prod_valid, prod_last, acc_clr, out_ready,
        output prod_ready, out_data, out_count, out_ovf, out_valid
    );
endinterface

// File: rtl/mac_acc_narrow.sv
// Reduces the wide accumulator to a 64-bit signed result plus overflow flag.
// Define MAC_ACC_SAT_EN to clamp out-of-range sums; otherwise they wrap.
module mac_acc_narrow
    import mac_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [OUT_W-1:0] data_o,
    output logic             ovf_o
);
    logic [ACC_W-OUT_W:0] upper;

    // The value fits when every bit from the 64-bit sign position up is equal.
    always_comb begin
        upper = acc_i[ACC_W-1:OUT_W-1];
        ovf_o = !((&upper) || !(|upper));
    end

`ifdef MAC_ACC_SAT_EN
    always_comb begin
        data_o = acc_i[OUT_W-1:0];
        if (ovf_o) begin
            data_o = acc_i[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    always_comb begin
        data_o = acc_i[OUT_W-1:0];
    end
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Registered multiply-accumulate back end: input register, wide accumulator,
// and one held result per vector. Optional clamping: MAC_ACC_SAT_EN.
module mac_accumulator
    import mac_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic    clk,
    input  logic    rst,
    mac_acc_if.slave bus
);
    s1_t              s1_q, s1_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_next;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
    logic             first_q, first_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_valid_q, out_valid_d;

    logic             stall, prod_ready, accept, consume, load;
    logic [OUT_W-1:0] narrow_data;
    logic             narrow_ovf;

    always_comb begin
        stall      = out_valid_q && !bus.out_ready;
        prod_ready = !rst && !stall;
        accept     = bus.prod_valid && prod_ready;
        // A clear drops the S1 term rather than folding it into the old vector.
        consume    = s1_q.valid && !stall && !bus.acc_clr;
        load       = consume && s1_q.last;
        acc_next   = (first_q ? '0 : acc_q)
                   + {{(ACC_W-OUT_W){s1_q.prod[OUT_W-1]}}, s1_q.prod};
        if (first_q) begin
            cnt_next = CNT_W'(1);
        end else if (&cnt_q) begin
            cnt_next = cnt_q;
        end else begin
            cnt_next = cnt_q + 1'b1;
        end
    end

    mac_acc_narrow #(.ACC_W(ACC_W)) u_narrow (
        .acc_i  (acc_next),
        .data_o (narrow_data),
        .ovf_o  (narrow_ovf)
    );

    always_comb begin
        s1_d        = s1_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        if (!stall) begin
            s1_d.valid = accept;
            if (accept) begin
                s1_d.prod = bus.prod;
                s1_d.last = bus.prod_last;
            end
        end else if (bus.acc_clr) begin
            s1_d.valid = 1'b0;
        end

        if (consume) begin
            acc_d   = acc_next;
            cnt_d   = cnt_next;
            first_d = s1_q.last;
        end
        if (bus.acc_clr) begin
            first_d = 1'b1;
        end

        // A fresh result wins over the consumer taking the previous one.
        if (load) begin
            out_data_d  = narrow_data;
            out_count_d = cnt_next;
            out_ovf_d   = narrow_ovf;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.prod_ready = prod_ready;
    assign bus.out_data   = out_data_q;
    assign bus.out_count  = out_count_q;
    assign bus.out_ovf    = out_ovf_q;
    assign bus.out_valid  = out_valid_q;

endmodule
